// File: rtl/custom_seq_pkg.sv
// Shared constants for the custom sequence counter: the 7-entry value table and index type.
package custom_seq_pkg;

    localparam int unsigned SEQ_LEN_C = 7;
    localparam int unsigned SEQ_VW    = 4;
    localparam int unsigned IDX_W     = 3;

    typedef logic [IDX_W-1:0] seq_idx_t;

    localparam seq_idx_t IDX_LAST = seq_idx_t'(SEQ_LEN_C - 1);

    // Entry k sits in slice [k]; S0..S6 = 0, 2, 3, 6, 8, 9, 15
    localparam logic [SEQ_LEN_C-1:0][SEQ_VW-1:0] SEQ_TABLE = {
        4'd15, 4'd9, 4'd8, 4'd6, 4'd3, 4'd2, 4'd0
    };

    // Table read that returns 0 for the unused index code
    function automatic logic [SEQ_VW-1:0] seq_value(input seq_idx_t i);
        logic [SEQ_VW-1:0] v;
        v = '0;
        for (int k = 0; k < SEQ_LEN_C; k++) begin
            if (i == seq_idx_t'(k)) begin
                v = SEQ_TABLE[k];
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/seq_value_encoder.sv
// Combinational value -> {hit, index} lookup into the sequence table, used on the load path.
module seq_value_encoder
    import custom_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] value,
    output logic             hit_c,
    output seq_idx_t         idx_c
);

    // Full-width match against each zero-extended entry
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        for (int k = 0; k < SEQ_LEN_C; k++) begin
            if (value == WIDTH'(SEQ_TABLE[k])) begin
                hit_c = 1'b1;
                idx_c = seq_idx_t'(k);
            end
        end
    end

endmodule

// File: rtl/custom_seq_counter.sv
// Up/down counter stepping through the fixed sequence 0,2,3,6,8,9,15 with parallel load.
// Build option: define SEQ_SATURATE_EN to make counting stop at the table ends instead of wrapping.
module custom_seq_counter
    import custom_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned SEQ_LEN = 7,
    parameter int unsigned IDXW    = 3
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             load,
    input  logic             count_en,
    input  logic             up,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] Q
);

    localparam logic [IDXW-1:0] LAST = IDXW'(SEQ_LEN - 1);

    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] idx_nxt;
    logic            enc_hit;
    seq_idx_t        enc_idx;

    seq_value_encoder #(
        .WIDTH (WIDTH)
    ) u_enc (
        .value (data_in),
        .hit_c (enc_hit),
        .idx_c (enc_idx)
    );

    // Next index: load, then illegal-state recovery, then counting, else hold
    always_comb begin
        idx_nxt = idx;
        if (load) begin
            idx_nxt = enc_hit ? IDXW'(enc_idx) : '0;
        end else if (idx > LAST) begin
            idx_nxt = '0;
        end else if (count_en) begin
            if (up) begin
`ifdef SEQ_SATURATE_EN
                idx_nxt = (idx == LAST) ? LAST : idx + IDXW'(1);
`else
                idx_nxt = (idx == LAST) ? '0 : idx + IDXW'(1);
`endif
            end else begin
`ifdef SEQ_SATURATE_EN
                idx_nxt = (idx == '0) ? '0 : idx - IDXW'(1);
`else
                idx_nxt = (idx == '0) ? LAST : idx - IDXW'(1);
`endif
            end
        end
    end

    // Index register with Q registered from the same next-index decode
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            idx <= '0;
            Q   <= '0;
        end else begin
            idx <= idx_nxt;
            Q   <= WIDTH'(seq_value(seq_idx_t'(idx_nxt)));
        end
    end

endmodule

// File: tb/tb_custom_seq_counter.sv
// Directed self-checking bench for custom_seq_counter (default 4-bit build).
module tb_custom_seq_counter;

`ifdef SEQ_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       Clk;
    logic       nReset;
    logic       load;
    logic       count_en;
    logic       up;
    logic [3:0] data_in;
    logic [3:0] Q;

    int vectors;
    int miscompares;

    custom_seq_counter #(
        .WIDTH   (4),
        .SEQ_LEN (7),
        .IDXW    (3)
    ) dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .load     (load),
        .count_en (count_en),
        .up       (up),
        .data_in  (data_in),
        .Q        (Q)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [3:0] exp);
        vectors++;
        assert (Q === exp)
        else begin
            miscompares++;
            $error("FAIL %s: Q=%0d expected %0d", tag, Q, exp);
        end
    endtask

    // One clock edge, then settle to the falling edge for sampling and driving
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nReset   = 1'b0;
        load     = 1'b0;
        count_en = 1'b0;
        up       = 1'b1;
        data_in  = '0;

        // Reset held across two clocks, then released
        step();
        step();
        check("reset_hold", 4'd0);
        nReset = 1'b1;
        step();
        check("reset_release", 4'd0);

        // Load 6 then count up four times, wrapping past 15
        load = 1'b1; data_in = 4'd6;
        step();
        check("load6_up", 4'd6);
        load = 1'b0; count_en = 1'b1; up = 1'b1;
        step(); check("up_1", 4'd8);
        step(); check("up_2", 4'd9);
        step(); check("up_3", 4'd15);
        step(); check("up_wrap", SAT ? 4'd15 : 4'd0);
        count_en = 1'b0;
        step(); check("hold", SAT ? 4'd15 : 4'd0);

        // Reset asserted in the middle of counting acts without a clock
        load = 1'b1; data_in = 4'd6;
        step(); check("load6_mid", 4'd6);
        load = 1'b0; count_en = 1'b1; up = 1'b1;
        step(); check("mid_up", 4'd8);
        nReset = 1'b0;
        #1;
        check("reset_async", 4'd0);
        @(negedge Clk);
        check("reset_dominates", 4'd0);
        nReset = 1'b1;
        step(); check("after_reset_up", 4'd2);

        // Load 6 then count down four times, wrapping below 0
        load = 1'b1; count_en = 1'b0; data_in = 4'd6;
        step(); check("load6_down", 4'd6);
        load = 1'b0; count_en = 1'b1; up = 1'b0;
        step(); check("down_1", 4'd3);
        step(); check("down_2", 4'd2);
        step(); check("down_3", 4'd0);
        step(); check("down_wrap", SAT ? 4'd0 : 4'd15);

        // Load has priority over counting and takes no step
        load = 1'b1; count_en = 1'b1; up = 1'b1; data_in = 4'd9;
        step(); check("load_prio", 4'd9);

        // Non-member loads fall back to S0
        load = 1'b1; count_en = 1'b0; data_in = 4'd5;
        step(); check("load_nonmember5", 4'd0);
        data_in = 4'd14;
        step(); check("load_nonmember14", 4'd0);

        // Load 15 and count down one step
        data_in = 4'd15;
        step(); check("load15", 4'd15);
        load = 1'b0; count_en = 1'b1; up = 1'b0;
        step(); check("down_from15", 4'd9);

        // Direction changes on consecutive cycles
        load = 1'b1; count_en = 1'b0; data_in = 4'd8;
        step(); check("load8", 4'd8);
        load = 1'b0; count_en = 1'b1; up = 1'b1;
        step(); check("dir_up", 4'd9);
        up = 1'b0;
        step(); check("dir_down1", 4'd8);
        step(); check("dir_down2", 4'd6);

        // Saturation-sensitive ends: up from 15, down from 0
        load = 1'b1; count_en = 1'b0; data_in = 4'd15;
        step(); check("load15_end", 4'd15);
        load = 1'b0; count_en = 1'b1; up = 1'b1;
        step(); check("end_up1", SAT ? 4'd15 : 4'd0);
        step(); check("end_up2", SAT ? 4'd15 : 4'd2);
        load = 1'b1; count_en = 1'b0; data_in = 4'd0;
        step(); check("load0_end", 4'd0);
        load = 1'b0; count_en = 1'b1; up = 1'b0;
        step(); check("end_down", SAT ? 4'd0 : 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
